// File: rtl/decimate_multi.sv
// Multi-channel decimator for time-interleaved sample streams. Each channel either keeps the last
// sample of every 2^K-sample group (pick) or outputs the rounded boxcar average of the group (avg).
module decimate_multi #(
  parameter int DATA_IN_BITS   = 17,
  parameter int DATA_OUT_BITS  = 17,
  parameter int NUM_CHANNELS   = 4,
  parameter int CHANNEL_BITS   = 2,
  parameter int MAX_RATIO_LOG2 = 5,
  parameter int RATIO_BITS     = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            sync_clr,
  input  logic                            mode,
  input  logic [RATIO_BITS-1:0]           ratio_log2,
  input  logic                            data_in_ready,
  input  logic [CHANNEL_BITS-1:0]         data_in_channel,
  input  logic signed [DATA_IN_BITS-1:0]  data_in,
  output logic                            data_out_ready,
  output logic [CHANNEL_BITS-1:0]         data_out_channel,
  output logic signed [DATA_OUT_BITS-1:0] data_out
);

  localparam int ACC_W = DATA_IN_BITS + MAX_RATIO_LOG2;
  localparam int CNT_W = (MAX_RATIO_LOG2 > 0) ? MAX_RATIO_LOG2 : 1;
  localparam int EXT_W = (ACC_W + 1 > DATA_OUT_BITS) ? ACC_W + 1 : DATA_OUT_BITS;
  localparam logic signed [EXT_W-1:0] OUT_MAX =
    {{(EXT_W - DATA_OUT_BITS + 1){1'b0}}, {(DATA_OUT_BITS - 1){1'b1}}};
  localparam logic signed [EXT_W-1:0] OUT_MIN = ~OUT_MAX;

  logic [RATIO_BITS-1:0]   k_q, k_in;
  logic                    mode_q;
  logic [CNT_W-1:0]        cnt_q [NUM_CHANNELS];
  logic [CNT_W-1:0]        cnt_d [NUM_CHANNELS];
  logic signed [ACC_W-1:0] acc_q [NUM_CHANNELS];
  logic signed [ACC_W-1:0] acc_d [NUM_CHANNELS];

  logic                       out_valid_q, out_valid_d;
  logic [CHANNEL_BITS-1:0]    out_chan_q, out_chan_d;
  logic [DATA_OUT_BITS-1:0]   out_data_q, out_data_d;

  logic                    clr, accept, done;
  logic [CNT_W-1:0]        sel_cnt, cnt_eff;
  logic signed [ACC_W-1:0] sel_acc, acc_new;
  logic [CNT_W:0]          group_last;
  logic signed [ACC_W:0]   acc_wide, half, rounded;
  logic signed [EXT_W-1:0] pre_sat;

  // NOTE: combinational logic uses blocking '=' with every output given a default first, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    k_in = (ratio_log2 > RATIO_BITS'(MAX_RATIO_LOG2)) ? RATIO_BITS'(MAX_RATIO_LOG2) : ratio_log2;
    // A configuration change restarts every group exactly like sync_clr.
    clr    = sync_clr || (k_in != k_q) || (mode != mode_q);
    accept = data_in_ready && (int'(data_in_channel) < NUM_CHANNELS);

    sel_cnt = '0;
    sel_acc = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (data_in_channel == CHANNEL_BITS'(c)) begin
        sel_cnt = cnt_q[c];
        sel_acc = acc_q[c];
      end
    end
    cnt_eff = clr ? '0 : sel_cnt;

    group_last = ((CNT_W + 1)'(1) << k_in) - (CNT_W + 1)'(1);
    done       = ({1'b0, cnt_eff} == group_last);
    acc_new    = ((cnt_eff == '0) ? ACC_W'(0) : sel_acc) + ACC_W'(data_in);

    // One extra bit keeps the rounding add from wrapping; K=0 gives half=0 and no shift.
    acc_wide = {acc_new[ACC_W-1], acc_new};
    half     = ((ACC_W + 1)'(1) << k_in) >> 1;
    rounded  = (acc_wide + half) >>> k_in;

    pre_sat = mode ? EXT_W'(rounded) : EXT_W'(data_in);

    for (int c = 0; c < NUM_CHANNELS; c++) begin
      cnt_d[c] = clr ? '0 : cnt_q[c];
      acc_d[c] = clr ? '0 : acc_q[c];
      if (accept && (data_in_channel == CHANNEL_BITS'(c))) begin
        cnt_d[c] = done ? '0 : cnt_eff + CNT_W'(1);
        acc_d[c] = acc_new;
      end
    end

    out_valid_d = accept && done;
    out_chan_d  = out_chan_q;
    out_data_d  = out_data_q;
    if (out_valid_d) begin
      out_chan_d = data_in_channel;
      if (pre_sat > OUT_MAX)      out_data_d = OUT_MAX[DATA_OUT_BITS-1:0];
      else if (pre_sat < OUT_MIN) out_data_d = OUT_MIN[DATA_OUT_BITS-1:0];
      else                        out_data_d = pre_sat[DATA_OUT_BITS-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      k_q         <= k_in;
      mode_q      <= mode;
      out_valid_q <= 1'b0;
      out_chan_q  <= '0;
      out_data_q  <= '0;
      // NOTE: the per-channel arrays are flops, not RAM, because reset must discard every
      // partial group; resetting them here is intentional.
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        cnt_q[c] <= '0;
        acc_q[c] <= '0;
      end
    end else begin
      k_q         <= k_in;
      mode_q      <= mode;
      out_valid_q <= out_valid_d;
      out_chan_q  <= out_chan_d;
      out_data_q  <= out_data_d;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        cnt_q[c] <= cnt_d[c];
        acc_q[c] <= acc_d[c];
      end
    end
  end

  assign data_out_ready   = out_valid_q;
  assign data_out_channel = out_chan_q;
  assign data_out         = signed'(out_data_q);

endmodule

// File: tb/tb_decimate_multi.sv
// Bench for decimate_multi: directed scenarios plus randomized traffic, all checked every cycle
// against a group-sum reference model (12-bit output, 3-bit channel tags, 4 channels).
module tb_decimate_multi;

  localparam int DIB = 17;
  localparam int DOB = 12;
  localparam int NCH = 4;
  localparam int CHB = 3;
  localparam int MAXK = 5;
  localparam int RB = 3;

  logic                  clk = 1'b0;
  logic                  rst, sync_clr, mode, data_in_ready;
  logic [RB-1:0]         ratio_log2;
  logic [CHB-1:0]        data_in_channel;
  logic signed [DIB-1:0] data_in;
  logic                  data_out_ready;
  logic [CHB-1:0]        data_out_channel;
  logic signed [DOB-1:0] data_out;

  decimate_multi #(
    .DATA_IN_BITS(DIB), .DATA_OUT_BITS(DOB), .NUM_CHANNELS(NCH),
    .CHANNEL_BITS(CHB), .MAX_RATIO_LOG2(MAXK), .RATIO_BITS(RB)
  ) dut (
    .clk(clk), .rst(rst), .sync_clr(sync_clr), .mode(mode), .ratio_log2(ratio_log2),
    .data_in_ready(data_in_ready), .data_in_channel(data_in_channel), .data_in(data_in),
    .data_out_ready(data_out_ready), .data_out_channel(data_out_channel), .data_out(data_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int pulses = 0;

  // Stimulus state driven on each step.
  bit g_rst = 1'b0, g_clr = 1'b0, g_mode = 1'b0;
  int g_ratio = 0;

  // Reference model: running sum and sample count of the open group per channel.
  longint m_sum [NCH];
  int     m_n   [NCH];
  int     m_k;
  bit     m_mode;
  bit     exp_v;
  int     exp_c;
  longint exp_d;

  task automatic check(input string tag, input longint got, input longint want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic longint sat_out(input longint v);
    longint hi = (longint'(1) <<< (DOB - 1)) - 1;
    longint lo = -(longint'(1) <<< (DOB - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic longint avg_round(input longint s, input int k);
    longint d   = longint'(1) <<< k;
    longint num = s + d / 2;
    longint q   = num / d;
    if ((num % d) != 0 && num < 0) q = q - 1;
    return q;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < NCH; c++) begin
      m_sum[c] = 0;
      m_n[c]   = 0;
    end
  endtask

  task automatic step(input bit rdy, input int tag, input int din);
    int kc;
    rst             = g_rst;
    sync_clr        = g_clr;
    mode            = g_mode;
    ratio_log2      = RB'(g_ratio);
    data_in_ready   = rdy;
    data_in_channel = CHB'(tag);
    data_in         = DIB'(din);

    kc = (g_ratio > MAXK) ? MAXK : g_ratio;
    if (!g_rst) begin
      model_clear();
      exp_v = 1'b0; exp_c = 0; exp_d = 0;
      m_k = kc; m_mode = g_mode;
    end else begin
      if (kc != m_k || g_mode != m_mode || g_clr) model_clear();
      m_k = kc; m_mode = g_mode;
      exp_v = 1'b0;
      if (rdy && tag < NCH) begin
        m_sum[tag] += din;
        m_n[tag]++;
        if (m_n[tag] == (1 << m_k)) begin
          exp_v = 1'b1;
          exp_c = tag;
          exp_d = sat_out(m_mode ? avg_round(m_sum[tag], m_k) : longint'(din));
          m_sum[tag] = 0;
          m_n[tag]   = 0;
        end
      end
    end

    @(posedge clk);
    #1;
    check("out_ready", data_out_ready, exp_v);
    check("out_chan", data_out_channel, exp_c);
    check("out_data", data_out, exp_d);
    if (data_out_ready) pulses++;
    g_clr = 1'b0;
  endtask

  task automatic do_reset();
    g_rst = 1'b0;
    step(1'b0, 0, 0);
    step(1'b1, 0, 77);
    g_rst = 1'b1;
  endtask

  initial begin
    int base;
    rst = 1'b0; sync_clr = 1'b0; mode = 1'b0; ratio_log2 = '0;
    data_in_ready = 1'b0; data_in_channel = '0; data_in = '0;
    model_clear();
    m_k = 0; m_mode = 1'b0; exp_v = 1'b0; exp_c = 0; exp_d = 0;

    // Pick, K=5, ramp 1..64 on channel 0: outputs 32 and 64.
    g_mode = 1'b0; g_ratio = 5;
    do_reset();
    check("reset_ready", data_out_ready, 0);
    check("reset_data", data_out, 0);
    pulses = 0;
    for (int i = 1; i <= 64; i++) begin
      step(1'b1, 0, i);
      if (i == 32) check("t1_first", data_out, 32);
    end
    check("t1_pulses", pulses, 2);
    check("t1_last", data_out, 64);

    // Avg, K=2, four interleaved constant channels.
    g_mode = 1'b1; g_ratio = 2;
    pulses = 0;
    for (int i = 0; i < 16; i++) step(1'b1, i % 4, 100 * (i % 4) - 150);
    check("t2_pulses", pulses, 4);
    check("t2_last", data_out, 150);

    // Avg, K=1 rounding toward +inf.
    g_ratio = 1;
    step(1'b1, 0, 3);
    step(1'b1, 0, 4);
    check("t3_pos", data_out, 4);
    step(1'b1, 0, -3);
    step(1'b1, 0, -4);
    check("t3_neg", data_out, -3);

    // Avg, K=3, saturation to 12 bits.
    g_ratio = 3;
    for (int i = 0; i < 8; i++) step(1'b1, 2, 65535);
    check("t4_max", data_out, 2047);
    for (int i = 0; i < 8; i++) step(1'b1, 2, -65536);
    check("t4_min", data_out, -2048);

    // Config change restarts groups; K=7 clamps to 32.
    g_mode = 1'b0; g_ratio = 3;
    step(1'b0, 0, 0);
    pulses = 0;
    for (int i = 0; i < 5; i++) step(1'b1, 0, 10 + i);
    g_ratio = 4;
    step(1'b1, 0, 500);
    for (int i = 0; i < 14; i++) step(1'b1, 0, 600 + i);
    check("t5_partial", pulses, 0);
    step(1'b1, 0, 700);
    check("t5_done", pulses, 1);
    g_ratio = 7;
    pulses = 0;
    for (int i = 0; i < 31; i++) step(1'b1, 1, i);
    check("t5_clamp_partial", pulses, 0);
    step(1'b1, 1, 31);
    check("t5_clamp_done", pulses, 1);

    // Reset mid-group and on the output pulse; dropped tags.
    g_mode = 1'b1; g_ratio = 2;
    step(1'b1, 1, 40);
    step(1'b1, 1, 40);
    do_reset();
    pulses = 0;
    step(1'b1, 1, 8);
    step(1'b1, 5, 1000);
    step(1'b1, 1, 8);
    step(1'b1, 7, 1000);
    step(1'b1, 1, 8);
    step(1'b1, 1, 12);
    check("t6_fresh", data_out, 9);
    check("t6_pulses", pulses, 1);
    g_rst = 1'b0;
    step(1'b0, 0, 0);
    check("t6_rst_clear", data_out_ready, 0);
    g_rst = 1'b1;
    step(1'b1, 0, 5);
    step(1'b1, 0, 5);
    g_clr = 1'b1;
    step(1'b1, 0, 5);
    step(1'b1, 0, 5);
    step(1'b1, 0, 5);
    check("t6_clr_partial", data_out_ready, 0);

    // Randomized traffic with occasional clears, config changes and resets.
    for (int i = 0; i < 4000; i++) begin
      base = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 400) - 200
                                         : $urandom_range(0, 131071) - 65536;
      if ($urandom_range(0, 199) == 0) g_ratio = $urandom_range(0, 7);
      if ($urandom_range(0, 299) == 0) g_mode = ~g_mode;
      if ($urandom_range(0, 149) == 0) g_clr = 1'b1;
      g_rst = ($urandom_range(0, 499) != 0);
      step($urandom_range(0, 9) < 8, $urandom_range(0, 5), base);
      g_rst = 1'b1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
